// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: active-low 7-segment patterns
// in {g,f,e,d,c,b,a} order and the default digit count.
package bcd_pkg;

  localparam int DEF_NUM_DIGITS = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = 7'h06;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic is_legal_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Bus between the BCD sum producer and the display scanner: load/data/blank
// controls in, multiplexed segment/anode drive and status out.
interface bcd_display_scan_if #(
  parameter int NUM_DIGITS = bcd_pkg::DEF_NUM_DIGITS
) ();

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic                      blank_lz;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;
  logic                      pending;

  modport master (
    output load, bcd_in, blank_lz,
    input  seg, an, frame_done, pending
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output seg, an, frame_done, pending
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Single BCD digit to active-low 7-segment pattern; codes above 9 show 'E'.
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_ERR;
    if (is_legal_bcd(digit_i)) seg_o = SEG_LUT[digit_i];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode scanner for a packed BCD value, with
// frame-synchronous data swap, leading-zero blanking and illegal-code 'E'.
module bcd_display_scan
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int CLK_DIV    = 1000,
  parameter int DIV_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  bcd_display_scan_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BCD_W-1:0]      shadow_q, shadow_d;
  logic [BCD_W-1:0]      disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  logic                  tick;
  logic                  frame_bnd;
  logic                  upper_zero;
  logic [3:0]            digits [NUM_DIGITS];
  logic [6:0]            dec_seg;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign frame_bnd = tick && (idx_q == IDX_LAST);

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) digits[i] = disp_q[4*i +: 4];
  end

  // True when the current digit and everything above it are literal zeros.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_q) && digits[j] != 4'd0) upper_zero = 1'b0;
    end
  end

  bcd_to_seg7 u_dec (
    .digit_i (digits[idx_q]),
    .seg_o   (dec_seg)
  );

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (tick) idx_d = frame_bnd ? '0 : idx_q + IDX_W'(1);

    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    // A load landing on the boundary bypasses the shadow so it shows this frame.
    if (frame_bnd) begin
      pending_d = 1'b0;
      if (bus.load)       disp_d = bus.bcd_in;
      else if (pending_q) disp_d = shadow_q;
    end else if (bus.load) begin
      shadow_d  = bus.bcd_in;
      pending_d = 1'b1;
    end

    seg_d = (bus.blank_lz && idx_q != '0 && upper_zero) ? SEG_BLANK : dec_seg;
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_bnd;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with CLK_DIV=4, NUM_DIGITS=5.
module tb_bcd_display_scan;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  bcd_display_scan_if #(.NUM_DIGITS(N)) bus ();

  bcd_display_scan #(
    .NUM_DIGITS (N),
    .CLK_DIV    (4),
    .DIV_W      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0]     bcd;
    logic            blz;
    logic [4:0][6:0] segs;   // segs[d] = expected pattern of digit d
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_an(input int d, input string name);
    logic [4:0] pat;
    int t;
    pat = ~(5'b00001 << d);
    t = 0;
    while (bus.an !== pat && t < 40) begin
      @(negedge clk);
      t++;
    end
    check(name, {27'd0, bus.an}, {27'd0, pat});
  endtask

  task automatic wait_frame(input string name);
    int t;
    t = 0;
    while (bus.frame_done !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check(name, {31'd0, bus.frame_done}, 32'd1);
  endtask

  task automatic load_value(input logic [19:0] v);
    bus.bcd_in = v;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic check_frame(input logic [4:0][6:0] segs, input string tag);
    for (int d = 0; d < N; d++) begin
      wait_an(d, $sformatf("%s an d%0d", tag, d));
      check($sformatf("%s seg d%0d", tag, d), {25'd0, bus.seg}, {25'd0, segs[d]});
    end
  endtask

  initial begin
    int c;

    bus.load     = 1'b0;
    bus.bcd_in   = '0;
    bus.blank_lz = 1'b0;

    vecs[0] = '{20'h12345, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
    vecs[1] = '{20'h00070, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40}};
    vecs[2] = '{20'h00000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{20'h0A009, 1'b0, {7'h40, 7'h06, 7'h40, 7'h40, 7'h10}};
    vecs[4] = '{20'h0A009, 1'b1, {7'h7F, 7'h06, 7'h40, 7'h40, 7'h10}};
    vecs[5] = '{20'h12345, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
    vecs[6] = '{20'h00000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[7] = '{20'h90000, 1'b1, {7'h10, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[8] = '{20'h0F0E0, 1'b1, {7'h7F, 7'h06, 7'h40, 7'h06, 7'h40}};

    // Reset held with clock running
    repeat (3) @(negedge clk);
    check("rst an",         {27'd0, bus.an},         32'h1F);
    check("rst seg",        {25'd0, bus.seg},        32'h7F);
    check("rst frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst pending",    {31'd0, bus.pending},    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst an",      {27'd0, bus.an},      32'h1E);
    check("post-rst seg",     {25'd0, bus.seg},     32'h40);
    check("post-rst pending", {31'd0, bus.pending}, 32'd0);

    // Table of display values
    for (int i = 0; i < 9; i++) begin
      bus.blank_lz = vecs[i].blz;
      load_value(vecs[i].bcd);
      wait_frame($sformatf("v%0d frame", i));
      check_frame(vecs[i].segs, $sformatf("v%0d", i));
    end

    // Dwell and frame period
    bus.blank_lz = 1'b0;
    load_value(20'h12345);
    wait_frame("tim frame");
    wait_an(0, "tim an d0");
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.an === 5'b11110 && c < 10);
    check("digit dwell", c, 32'd4);
    wait_frame("tim frame2");
    @(negedge clk);
    c = 1;
    check("frame_done width", {31'd0, bus.frame_done}, 32'd0);
    while (bus.frame_done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("frame period", c, 32'd20);

    // Two loads mid-frame: old frame completes, last load wins at boundary
    wait_frame("mid frame");
    wait_an(0, "mid an d0");
    wait_an(1, "mid an d1");
    load_value(20'h11111);
    @(negedge clk);
    load_value(20'h22222);
    check("mid pending", {31'd0, bus.pending}, 32'd1);
    wait_an(2, "mid old an d2");
    check("mid old seg d2", {25'd0, bus.seg}, 32'h30);
    wait_an(3, "mid old an d3");
    check("mid old seg d3", {25'd0, bus.seg}, 32'h24);
    wait_an(4, "mid old an d4");
    check("mid old seg d4", {25'd0, bus.seg}, 32'h79);
    check("mid pending d4", {31'd0, bus.pending}, 32'd1);
    wait_frame("mid swap frame");
    check("mid pending clr", {31'd0, bus.pending}, 32'd0);
    check_frame({7'h24, 7'h24, 7'h24, 7'h24, 7'h24}, "mid new");

    // Load exactly on the boundary tick
    wait_frame("bnd frame");
    repeat (19) @(negedge clk);
    load_value(20'h98765);
    check("bnd frame_done", {31'd0, bus.frame_done}, 32'd1);
    check("bnd pending",    {31'd0, bus.pending},    32'd0);
    @(negedge clk);
    check("bnd an d0",  {27'd0, bus.an},  32'h1E);
    check("bnd seg d0", {25'd0, bus.seg}, 32'h12);
    wait_an(1, "bnd an d1");
    check("bnd seg d1", {25'd0, bus.seg}, 32'h02);
    check("bnd pending later", {31'd0, bus.pending}, 32'd0);

    // Asynchronous reset mid-frame with a value pending
    wait_frame("ar frame");
    load_value(20'h33333);
    check("ar pending before", {31'd0, bus.pending}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar an",         {27'd0, bus.an},         32'h1F);
    check("ar seg",        {25'd0, bus.seg},        32'h7F);
    check("ar pending",    {31'd0, bus.pending},    32'd0);
    check("ar frame_done", {31'd0, bus.frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar post an",  {27'd0, bus.an},  32'h1E);
    check("ar post seg", {25'd0, bus.seg}, 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
